// File: rtl/display_pkg.sv
// Shared glyph codes, input encodings and FSM state type for the 7-segment
// message display, plus the message-text lookup.
package display_pkg;

  localparam int MSG_LEN = 6;

  localparam logic [4:0] G_0     = 5'd0;
  localparam logic [4:0] G_1     = 5'd1;
  localparam logic [4:0] G_2     = 5'd2;
  localparam logic [4:0] G_3     = 5'd3;
  localparam logic [4:0] G_N     = 5'd4;
  localparam logic [4:0] G_I     = 5'd5;
  localparam logic [4:0] G_V     = 5'd6;
  localparam logic [4:0] G_E     = 5'd7;
  localparam logic [4:0] G_L     = 5'd8;
  localparam logic [4:0] G_C     = 5'd9;
  localparam logic [4:0] G_U     = 5'd10;
  localparam logic [4:0] G_D     = 5'd11;
  localparam logic [4:0] G_R     = 5'd12;
  localparam logic [4:0] G_P     = 5'd13;
  localparam logic [4:0] G_BLANK = 5'd31;

  localparam logic [1:0] MSG_NIVEL  = 2'd0;
  localparam logic [1:0] MSG_VENCEU = 2'd1;
  localparam logic [1:0] MSG_PERDEU = 2'd2;
  localparam logic [1:0] MSG_BLANK  = 2'd3;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_SCROLL = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2,
    ST_BLINK  = 2'd3
  } state_t;

  // Glyph at character position idx (0 = leftmost) of the selected message.
  function automatic logic [4:0] msg_char(input logic [1:0] msg,
                                          input logic [1:0] lvl,
                                          input logic [2:0] idx);
    logic [4:0] lvl_g;
    logic [4:0] ch;
    case (lvl)
      2'd0:    lvl_g = G_0;
      2'd1:    lvl_g = G_1;
      2'd2:    lvl_g = G_2;
      default: lvl_g = G_3;
    endcase
    ch = G_BLANK;
    case (msg)
      MSG_NIVEL: begin
        case (idx)
          3'd0:    ch = G_N;
          3'd1:    ch = G_I;
          3'd2:    ch = G_V;
          3'd3:    ch = G_E;
          3'd4:    ch = G_L;
          3'd5:    ch = lvl_g;
          default: ch = G_BLANK;
        endcase
      end
      MSG_VENCEU: begin
        case (idx)
          3'd0:    ch = G_V;
          3'd1:    ch = G_E;
          3'd2:    ch = G_N;
          3'd3:    ch = G_C;
          3'd4:    ch = G_E;
          3'd5:    ch = G_U;
          default: ch = G_BLANK;
        endcase
      end
      MSG_PERDEU: begin
        case (idx)
          3'd0:    ch = G_P;
          3'd1:    ch = G_E;
          3'd2:    ch = G_R;
          3'd3:    ch = G_D;
          3'd4:    ch = G_E;
          3'd5:    ch = G_U;
          default: ch = G_BLANK;
        endcase
      end
      default: ch = G_BLANK;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/display_glyph_rom.sv
// Combinational glyph-code to segment lookup, {g,f,e,d,c,b,a} active-high.
module display_glyph_rom
  import display_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (code)
      G_0:     seg = 7'b0111111;
      G_1:     seg = 7'b0000110;
      G_2:     seg = 7'b1011011;
      G_3:     seg = 7'b1001111;
      G_N:     seg = 7'b0110111;
      G_I:     seg = 7'b0000100;
      G_V:     seg = 7'b0111110;
      G_E:     seg = 7'b1111001;
      G_L:     seg = 7'b0111000;
      G_C:     seg = 7'b1011000;
      G_U:     seg = 7'b0011100;
      G_D:     seg = 7'b1011110;
      G_R:     seg = 7'b1010000;
      G_P:     seg = 7'b1110011;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/display_msg_ctrl.sv
// Message controller for an N-digit 7-segment display: static, scrolling or
// blinking rendering of one of three 6-character messages.
module display_msg_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS  = 6,
  parameter int TICK_DIV  = 25000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [1:0]            msg_sel,
  input  logic [1:0]            level,
  input  logic [1:0]            mode,
  output logic [7*N_DIGITS-1:0] hex_flat,
  output logic                  busy,
  output logic                  wrap,
  output logic [1:0]            state_dbg
);

  localparam int PAD_LEN = MSG_LEN + N_DIGITS;
  localparam int OFF_W   = $clog2(PAD_LEN);
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [OFF_W-1:0]   OFF_LAST   = OFF_W'(PAD_LEN - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [OFF_W:0]     PAD_LEN_W  = (OFF_W+1)'(PAD_LEN);
  localparam logic [OFF_W:0]     MSG_LEN_W  = (OFF_W+1)'(MSG_LEN);

  logic [1:0]            rst_sync;
  logic                  rst_n_int;
  state_t                state, state_nxt;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic [OFF_W-1:0]      offset;
  logic [1:0]            msg_q;
  logic [1:0]            level_q;
  logic                  show;
  logic                  wrap_nxt;
  logic [OFF_W-1:0]      win_base;
  logic [7*N_DIGITS-1:0] segs;

  // Assert asynchronously, release two edges after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // load is a single-cycle strobe; it overrides whatever is in progress.
  always_comb begin
    state_nxt = state;
    if (load) begin
      if (msg_sel == MSG_BLANK) begin
        state_nxt = ST_IDLE;
      end else begin
        case (mode)
          MODE_STATIC: state_nxt = ST_STATIC;
          MODE_SCROLL: state_nxt = ST_SCROLL;
          MODE_BLINK:  state_nxt = ST_BLINK;
          default:     state_nxt = ST_STATIC;
        endcase
      end
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      tick_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      offset      <= '0;
      msg_q       <= 2'd0;
      level_q     <= 2'd0;
    end else if (load) begin
      tick_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      offset      <= '0;
      msg_q       <= msg_sel;
      level_q     <= level;
    end else begin
      case (state)
        ST_SCROLL: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            offset   <= (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        ST_BLINK: begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end
        end
        default: begin
          tick_cnt    <= '0;
          blink_cnt   <= '0;
          blink_phase <= 1'b0;
          offset      <= '0;
        end
      endcase
    end
  end

  assign show = (state == ST_STATIC) || (state == ST_SCROLL) ||
                ((state == ST_BLINK) && !blink_phase);
  assign win_base = (state == ST_SCROLL) ? offset : '0;
  assign wrap_nxt = !load && (state == ST_SCROLL) &&
                    (tick_cnt == TICK_LAST) && (offset == OFF_LAST);

  // Digit i shows window position N_DIGITS-1-i of the padded string.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    localparam int J = N_DIGITS - 1 - i;
    logic [OFF_W:0] sum;
    logic [OFF_W:0] pos;
    logic [4:0]     ch;
    assign sum = {1'b0, win_base} + (OFF_W+1)'(J);
    assign pos = (sum >= PAD_LEN_W) ? sum - PAD_LEN_W : sum;
    assign ch  = (show && (pos < MSG_LEN_W)) ? msg_char(msg_q, level_q, pos[2:0])
                                             : G_BLANK;
    display_glyph_rom u_rom (
      .code (ch),
      .seg  (segs[7*i +: 7])
    );
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      hex_flat <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      hex_flat <= segs;
      busy     <= (state != ST_IDLE);
      wrap     <= wrap_nxt;
    end
  end

endmodule

// File: doc/display_msg_ctrl.md
DISPLAY_MSG_CTRL -- requirements
Module: display_msg_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 6: number of 7-segment digits driven; legal range 4..8.
REQ-002 Parameter TICK_DIV, default 25000000: clock cycles per scroll step; must be >= 2.
REQ-003 Parameter BLINK_DIV, default 12500000: clock cycles per blink phase; must be >= 2.
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  one-cycle request to latch msg_sel, level and mode.
REQ-007 msg_sel  input  2  message select: 0 "nivelX", 1 "venceu", 2 "perdeu", 3 blank.
REQ-008 level  input  2  digit X shown in the "nivelX" message (0..3).
REQ-009 mode  input  2  display mode: 0 static, 1 scroll, 2 blink, 3 treated as static.
REQ-010 hex_flat  output  7*N_DIGITS  segment data; digit i occupies bits [7i+6:7i]; digit 0 is rightmost.
REQ-011 busy  output  1  high whenever a non-blank message is displayed.
REQ-012 wrap  output  1  one-cycle pulse when a scroll pass completes.

Function
REQ-013 Segment encoding SHALL be {g,f,e,d,c,b,a}, active-high; blank = 7'b0000000.
REQ-014 Messages SHALL be 6 characters, leftmost first:
- "nivelX" where X = level
- "venceu"
- "perdeu"
REQ-015 The FSM SHALL have states IDLE, STATIC, SCROLL and BLINK.
- A load with msg_sel=3 enters IDLE.
- Otherwise load enters the state selected by mode.
REQ-016 A load sampled at edge t SHALL clear the tick counter, blink phase and scroll offset, and SHALL update hex_flat and busy at edge t+1.
REQ-017 A load in any state, including mid-scroll or mid-blink, SHALL restart the operation with the newly latched values.
REQ-018 Inputs msg_sel, level and mode SHALL be ignored while load is low.
REQ-019 IDLE: hex_flat all zero, busy=0, wrap=0, counters held at zero.
REQ-020 STATIC: the window shows padded-string positions 0..N_DIGITS-1 on digits N_DIGITS-1..0.
- Padded string = message followed by N_DIGITS blanks.
REQ-021 SCROLL: the tick counter runs 0..TICK_DIV-1. On reaching TICK_DIV-1 it returns to 0 and the offset increments.
- Window position j (j=0 leftmost) shows padded[(offset+j) mod (6+N_DIGITS)].
REQ-022 SCROLL: when the offset wraps from 6+N_DIGITS-1 to 0, wrap SHALL pulse high for exactly that one cycle; scrolling continues indefinitely.
REQ-023 BLINK: the STATIC image alternates with all-blank; the phase toggles every BLINK_DIV cycles, starting with the image visible.
- busy stays 1 in both phases.
REQ-024 Counter widths SHALL be $clog2 of their terminal value; no counter overflows for any legal parameter value.

Reset
REQ-025 While reset_n=0, regardless of clock:
- State = IDLE.
- hex_flat = 0, busy = 0, wrap = 0.
- All counters and latched inputs = 0.
REQ-026 Reset deassertion SHALL be synchronised so the first active edge is deterministic; operation resumes only on a subsequent load.

Structure
REQ-027 A shared package display_pkg SHALL hold:
- the glyph constants (0-3, n, i, v, e, l, c, u, d, r, p, blank)
- the msg_sel and mode encodings
- the FSM state typedef
REQ-028 Character-to-segment mapping SHALL live in a combinational sub-module display_glyph_rom (5-bit char code in, 7-bit segments out), instantiated per digit.
REQ-029 hex_flat, busy and wrap SHALL be driven directly from flops.

Verification (N_DIGITS=6, TICK_DIV=4, BLINK_DIV=3)
REQ-030 Reset pulse -> hex_flat=0, busy=0, wrap=0.
REQ-031 load with msg_sel=0, level=2, mode=0 -> next edge:
- hex_flat[6:0]=1011011
- hex_flat[41:35]=0110111
- busy=1
REQ-032 load with "venceu", mode=1 -> after 4 cycles:
- hex_flat[41:35]=1111001 (e)
- hex_flat[6:0]=0000000
- wrap pulses once at cycle 48, when the offset returns to 0.
REQ-033 load with "perdeu", mode=2 -> blank for cycles 4-6, image again at cycle 7, busy=1 throughout.
REQ-034 A new load at scroll offset 5 -> offset=0 and the new image on the next edge; no wrap pulse.
REQ-035 reset_n low mid-scroll -> outputs go to zero immediately without a clock edge; they stay zero after release until a load.
